// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-1 master sequencer.
// Holds the FSM encoding, link mode constants and the default frame width.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  localparam logic SPI_CPOL       = 1'b0;
  localparam logic SPI_CPHA       = 1'b1;
  localparam int   DEFAULT_DATA_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI mode-1 master: frames one DATA_W-bit word with CHIPSELECT, shifts MSB first,
// and returns the MISO reply in rx_data with a one-cycle done pulse.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCK,
  output logic              CHIPSELECT,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int CNT_MAX = max3(CS_SETUP, CLK_DIV, CS_HOLD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(DATA_W + 1);

  spi_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              sck_q;
  logic              cs_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;

  // cnt_q counts down from N-1, so each timed state lasts exactly N clk cycles.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the shift registers are plain flops, not memories, so they are
      // cleared with the rest of the state.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= SPI_CPOL;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_SETUP;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            tx_sh_q   <= tx_data;
            bit_cnt_q <= BIT_W'(DATA_W);
            cnt_q     <= CNT_W'(CS_SETUP - 1);
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_HIGH;
            sck_q   <= ~SPI_CPOL;
            mosi_q  <= tx_sh_q[DATA_W-1];
            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            cnt_q   <= CNT_W'(CLK_DIV - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HIGH: begin
          // Mode 1: the slave launched MISO on the rise, so capture it on the fall.
          if (cnt_q == '0) begin
            state_q   <= ST_LOW;
            sck_q     <= SPI_CPOL;
            rx_sh_q   <= {rx_sh_q[DATA_W-2:0], MISO};
            bit_cnt_q <= bit_cnt_q - 1'b1;
            cnt_q     <= CNT_W'(CLK_DIV - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_q == '0) begin
            if (bit_cnt_q != '0) begin
              state_q <= ST_HIGH;
              sck_q   <= ~SPI_CPOL;
              mosi_q  <= tx_sh_q[DATA_W-1];
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              cnt_q   <= CNT_W'(CLK_DIV - 1);
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= CNT_W'(CS_HOLD - 1);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q   <= ST_DONE;
            cs_q      <= 1'b1;
            rx_data_q <= rx_sh_q;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          // One extra busy cycle keeps CHIPSELECT high for at least two cycles.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_data    = rx_data_q;
  assign SCK        = sck_q;
  assign CHIPSELECT = cs_q;
  assign MOSI       = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural mode-1 slave.
// A second 16-bit, CLK_DIV=1 instance checks the fast-clock corner.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        busy, done, SCK, CHIPSELECT, MOSI;
  logic [7:0]  rx_data;
  logic        MISO = 1'b0;

  logic        start2 = 1'b0;
  logic [15:0] tx_data2 = '0;
  logic        busy2, done2, SCK2, CHIPSELECT2, MOSI2;
  logic [15:0] rx_data2;
  logic        MISO2 = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int lat;

  logic [7:0]  slave_tx = '0;
  logic [7:0]  slave_rx = '0;
  int          s_idx = 0;
  logic [15:0] slave2_rx = '0;

  int sck_rises = 0, cs_rises = 0, done_cnt = 0;
  int glitches = 0, sck_cs_bad = 0;
  int cs_hi_run = 0, min_gap = 999;
  logic prev_sck = 1'b0, prev_mosi = 1'b0;
  int rise2_n = 0, last_rise2 = 0, period_bad2 = 0;

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .SCK(SCK), .CHIPSELECT(CHIPSELECT), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2), .busy(busy2), .done(done2),
    .rx_data(rx_data2), .SCK(SCK2), .CHIPSELECT(CHIPSELECT2), .MOSI(MOSI2), .MISO(MISO2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Mode-1 slave: launches on SCK rise, samples MOSI on SCK fall.
  always @(negedge CHIPSELECT) s_idx = 0;
  always @(posedge SCK) begin
    MISO = slave_tx[7 - (s_idx % 8)];
    sck_rises++;
  end
  always @(negedge SCK) begin
    slave_rx = {slave_rx[6:0], MOSI};
    s_idx++;
  end
  always @(posedge CHIPSELECT) cs_rises++;

  always @(posedge SCK2) begin
    if (rise2_n > 0 && (cyc - last_rise2) != 2) period_bad2++;
    last_rise2 = cyc;
    rise2_n++;
  end
  always @(negedge SCK2) slave2_rx = {slave2_rx[14:0], MOSI2};

  always @(negedge clk) begin
    if (prev_sck && SCK && (MOSI !== prev_mosi)) glitches++;
    if (CHIPSELECT && SCK) sck_cs_bad++;
    if (done) done_cnt++;
    if (CHIPSELECT) cs_hi_run++;
    else begin
      if (cs_hi_run > 0 && cs_hi_run < min_gap) min_gap = cs_hi_run;
      cs_hi_run = 0;
    end
    prev_sck  = SCK;
    prev_mosi = MOSI;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] tx, input logic [7:0] reply);
    @(posedge clk);
    #1;
    tx_data  = tx;
    slave_tx = reply;
    start    = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        l = cyc - c0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  initial begin
    int r0, d0, cr0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck", SCK, 0);
    check("rst_cs", CHIPSELECT, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset after the 4th SCK rise aborts the frame
    r0 = sck_rises;
    d0 = done_cnt;
    launch(8'hC3, 8'h99);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sck_rises - r0 >= 4) break;
    end
    check("abort_rises", sck_rises - r0, 4);
    rst = 1'b0;
    @(negedge clk);
    check("abort_cs", CHIPSELECT, 1);
    check("abort_sck", SCK, 0);
    check("abort_busy", busy, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rx", rx_data, 0);

    // Basic frame: 0xA5 out, 0x3C back
    r0 = sck_rises;
    launch(8'hA5, 8'h3C);
    wait_done(lat);
    check("f1_latency", lat, 34);
    check("f1_rx", rx_data, 8'h3C);
    check("f1_slave_rx", slave_rx, 8'hA5);
    check("f1_rises", sck_rises - r0, 8);
    check("f1_busy_at_done", busy, 1);
    @(negedge clk);
    check("f1_done_pulse", done, 0);
    @(negedge clk);
    check("f1_busy_idle", busy, 0);

    // start during the frame and during DONE is ignored
    d0  = done_cnt;
    cr0 = cs_rises;
    launch(8'h5A, 8'h81);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 4 || k == 34) start = 1'b1;
      if (k == 5 || k == 35) start = 1'b0;
    end
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_cs_rises", cs_rises - cr0, 1);
    check("ign_busy", busy, 0);
    check("ign_rx", rx_data, 8'h81);
    check("ign_slave_rx", slave_rx, 8'h5A);

    // start held high: back-to-back frames with a >=2 cycle CS gap
    d0 = done_cnt;
    @(posedge clk);
    #1;
    tx_data  = 8'h33;
    slave_tx = 8'h0F;
    min_gap  = 999;
    start    = 1'b1;
    repeat (120) @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("b2b_frames", (done_cnt - d0) >= 3, 1);
    check("b2b_gap", min_gap >= 2, 1);
    check("b2b_rx", rx_data, 8'h0F);
    check("b2b_slave_rx", slave_rx, 8'h33);

    // All-ones / all-zeros patterns
    launch(8'hFF, 8'h00);
    wait_done(lat);
    check("ff_rx", rx_data, 8'h00);
    check("ff_slave_rx", slave_rx, 8'hFF);
    wait_idle();
    launch(8'h00, 8'hFF);
    wait_done(lat);
    check("00_rx", rx_data, 8'hFF);
    check("00_slave_rx", slave_rx, 8'h00);
    wait_idle();
    check("mosi_glitches", glitches, 0);
    check("sck_while_cs_high", sck_cs_bad, 0);

    // 16-bit, CLK_DIV=1 instance
    @(posedge clk);
    #1;
    tx_data2 = 16'hBEEF;
    start2   = 1'b1;
    @(posedge clk);
    #1;
    c0     = cyc;
    start2 = 1'b0;
    lat    = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done2) begin
        lat = cyc - c0;
        break;
      end
    end
    check("w16_latency", lat, 34);
    check("w16_rises", rise2_n, 16);
    check("w16_period", period_bad2, 0);
    check("w16_rx", rx_data2, 16'hFFFF);
    check("w16_slave_rx", slave2_rx, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
